// File: rtl/tff_counter_ctrl.sv
// Modulo-MOD_N up/down counter sequencer driving a WIDTH-bit toggle flip-flop bank.
// Define TFF_CTRL_ONESHOT_EN to stop the run on wrap and pulse done.
module tff_counter_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD_N = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] t_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_N - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD_N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] target;
  logic             wrap_up, wrap_dn, wrap;
`ifdef TFF_CTRL_ONESHOT_EN
  logic             done_q, done_d;
`endif

  // Load saturation and wrap detection; out-of-range q is treated as a wrap
  always_comb begin
    target  = ({1'b0, load_val} < MOD_X) ? load_val : MAX_V;
    wrap_up = (q_q >= MAX_V);
    wrap_dn = (q_q == '0) || (q_q > MAX_V);
    wrap    = up_dn ? wrap_up : wrap_dn;
  end

  // Next state with priority load > stop > start > count
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
`ifdef TFF_CTRL_ONESHOT_EN
    done_d  = 1'b0;
`endif
    if (load) begin
      q_d = target;
      if (state_q == RUN && stop) begin
        state_d = IDLE;
      end
    end else if (state_q == IDLE) begin
      if (start && !stop) begin
        state_d = RUN;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      if (up_dn) begin
        q_d = wrap_up ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = wrap_dn ? MAX_V : q_q - WIDTH'(1);
      end
      tc_d = wrap;
`ifdef TFF_CTRL_ONESHOT_EN
      if (wrap) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef TFF_CTRL_ONESHOT_EN
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_q ^ t_out;
      busy_q  <= (state_d == RUN);
      tc_q    <= tc_d;
`ifdef TFF_CTRL_ONESHOT_EN
      done_q  <= done_d;
`endif
    end
  end

  // Toggle vector is forced quiet while reset is held
  assign t_out = rst_n ? (q_q ^ q_d) : '0;
  assign q     = q_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
`ifdef TFF_CTRL_ONESHOT_EN
  assign done  = done_q;
`else
  assign done  = 1'b0;
`endif

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Randomized and directed bench for tff_counter_ctrl against an arithmetic reference model.
module tb_tff_counter_ctrl;
  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] t_out, q;
  logic       busy, tc, done;

  tff_counter_ctrl #(.WIDTH(4), .MOD_N(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up_dn(up_dn),
    .load(load), .load_val(load_val), .t_out(t_out), .q(q), .busy(busy),
    .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_q;
  bit m_run, m_tc, m_done;
  logic [3:0] t_obs, t_exp;
  int prev_q;

  function automatic void model_step(input bit s, input bit st, input bit ud, input bit ld,
                                     input int lv, output int nq, output bit nrun,
                                     output bit ntc, output bit ndone);
    bit w;
    nq = m_q; nrun = m_run; ntc = 0; ndone = 0; w = 0;
    if (ld) begin
      nq = (lv < N) ? lv : N - 1;
      if (m_run && st) nrun = 0;
    end else if (!m_run) begin
      if (s && !st) nrun = 1;
    end else if (st) begin
      nrun = 0;
    end else begin
      if (ud) begin
        w  = (m_q + 1 >= N);
        nq = w ? 0 : m_q + 1;
      end else begin
        w  = (m_q == 0 || m_q >= N);
        nq = w ? N - 1 : m_q - 1;
      end
      ntc = w;
`ifdef TFF_CTRL_ONESHOT_EN
      if (w) begin nrun = 0; ndone = 1; end
`endif
    end
  endfunction

  // Drive one clock of inputs, capture t_out before the edge, advance the model
  task automatic cycle(input bit s, input bit st, input bit ud, input bit ld, input logic [3:0] lv);
    int nq;
    bit nr, nt, nd;
    start = s; stop = st; up_dn = ud; load = ld; load_val = lv;
    model_step(s, st, ud, ld, int'(lv), nq, nr, nt, nd);
    #1;
    t_obs  = t_out;
    t_exp  = 4'(m_q ^ nq);
    prev_q = m_q;
    @(posedge clk);
    m_q = nq; m_run = nr; m_tc = nt; m_done = nd;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; up_dn = 0; load = 1; load_val = 4'd5;
    m_q = 0; m_run = 0; m_tc = 0; m_done = 0;
    #3;
    total++; if (t_out !== 4'd0) begin bad++; $display("FAIL rst_t_out: got %0d want 0", t_out); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL rst_q: got %0d want 0", q); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL rst_tc: got %b want 0", tc); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    load = 0;
    #4 rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    cycle(1, 0, 1, 0, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL up_start_busy: got %b want 1", busy); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL up_start_q: got %0d want 0", q); end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 0, 0);
      total++; if (t_obs !== t_exp) begin bad++; $display("FAIL up_t_out[%0d]: got %b want %b", i, t_obs, t_exp); end
      total++; if (q !== 4'(m_q)) begin bad++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q, m_q); end
      total++; if (tc !== m_tc) begin bad++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, m_tc); end
      total++; if (busy !== m_run) begin bad++; $display("FAIL up_busy[%0d]: got %b want %b", i, busy, m_run); end
      if (prev_q == 9) begin
        total++; if (t_obs !== 4'b1001) begin bad++; $display("FAIL up_wrap_t: got %b want 1001", t_obs); end
      end
    end
  endtask

  task automatic test_down_wrap();
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (i == 0) begin
        total++; if (t_obs !== 4'b1001) begin bad++; $display("FAIL dn_wrap_t: got %b want 1001", t_obs); end
        total++; if (q !== 4'd9) begin bad++; $display("FAIL dn_wrap_q: got %0d want 9", q); end
        total++; if (tc !== 1'b1) begin bad++; $display("FAIL dn_wrap_tc: got %b want 1", tc); end
      end else begin
        total++; if (q !== 4'(m_q)) begin bad++; $display("FAIL dn_q[%0d]: got %0d want %0d", i, q, m_q); end
        total++; if (tc !== 1'b0) begin bad++; $display("FAIL dn_tc[%0d]: got %b want 0", i, tc); end
      end
    end
  endtask

  task automatic test_load_priority();
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 4'd3);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 4'd14);
    total++; if (t_obs !== 4'b1010) begin bad++; $display("FAIL ld_t_out: got %b want 1010", t_obs); end
    total++; if (q !== 4'd9) begin bad++; $display("FAIL ld_q: got %0d want 9", q); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ld_busy: got %b want 0", busy); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL ld_tc: got %b want 0", tc); end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 0, 0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ss_busy[%0d]: got %b want 0", i, busy); end
      total++; if (q !== 4'd9) begin bad++; $display("FAIL ss_q[%0d]: got %0d want 9", i, q); end
      total++; if (t_obs !== 4'd0) begin bad++; $display("FAIL ss_t_out[%0d]: got %b want 0", i, t_obs); end
    end
  endtask

  task automatic test_oneshot();
    cycle(0, 0, 1, 1, 4'd8);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    total++; if (q !== 4'd9) begin bad++; $display("FAIL os_q9: got %0d want 9", q); end
    cycle(0, 0, 1, 0, 0);
    total++; if (q !== 4'd0) begin bad++; $display("FAIL os_q0: got %0d want 0", q); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL os_tc: got %b want 1", tc); end
`ifdef TFF_CTRL_ONESHOT_EN
    total++; if (done !== 1'b1) begin bad++; $display("FAIL os_done: got %b want 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_busy: got %b want 0", busy); end
    cycle(0, 0, 1, 0, 0);
    total++; if (q !== 4'd0) begin bad++; $display("FAIL os_hold_q: got %0d want 0", q); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL os_done_pulse: got %b want 0", done); end
`else
    total++; if (done !== 1'b0) begin bad++; $display("FAIL free_done: got %b want 0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL free_busy: got %b want 1", busy); end
    cycle(0, 0, 1, 0, 0);
    total++; if (q !== 4'd1) begin bad++; $display("FAIL free_q: got %0d want 1", q); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) == 0, ($urandom % 8) == 0, 1'($urandom), ($urandom % 10) == 0,
            4'($urandom));
      total++; if (t_obs !== t_exp) begin bad++; $display("FAIL rnd_t_out[%0d]: got %b want %b", i, t_obs, t_exp); end
      total++; if (q !== 4'(m_q)) begin bad++; $display("FAIL rnd_q[%0d]: got %0d want %0d", i, q, m_q); end
      total++; if (busy !== m_run) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_run); end
      total++; if (tc !== m_tc) begin bad++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, tc, m_tc); end
      total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done[%0d]: got %b want %b", i, done, m_done); end
    end
  endtask

  task automatic test_reset_midrun();
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 4'd5);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL mid_rst_q: got %0d want 0", q); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL mid_rst_tc: got %b want 0", tc); end
    total++; if (t_out !== 4'd0) begin bad++; $display("FAIL mid_rst_t_out: got %b want 0", t_out); end
    m_q = 0; m_run = 0; m_tc = 0; m_done = 0;
    #2 rst_n = 1'b1;
    cycle(0, 0, 1, 0, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rel_busy: got %b want 0", busy); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL mid_rel_q: got %0d want 0", q); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_contention();
    test_oneshot();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
